// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants and GF(2^8) helpers.
// The S-box is a plain lookup so synthesis can map it to LUTs or ROM as it sees fit.
package aes_pkg;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_encryptor_if.sv
// Host-side bundle for the AES core: load/start request and the result/done return.
interface aes_encryptor_if;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         done;
    logic [127:0] cipher_text;

    modport master (output start, plain_text, key, input done, cipher_text);
    modport slave  (input start, plain_text, key, output done, cipher_text);
endinterface

// File: rtl/aes_round_comb.sv
// One full AES round plus the matching key-schedule step, purely combinational.
// Byte i of a 128-bit word sits at bits [127-8i -: 8]; row = i%4, column = i/4.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic [7:0]   rcon,
    input  logic         last_round,
    output logic [127:0] next_state,
    output logic [127:0] next_round_key
);

    logic [7:0]  sub_bytes [16];
    logic [7:0]  shifted   [16];
    logic [7:0]  mixed     [16];
    logic [7:0]  sub_rot   [4];
    logic [31:0] key_word  [4];

    genvar gi;

    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        assign sub_bytes[gi] = sbox(state[127-8*gi -: 8]);
        assign shifted[gi]   = sub_bytes[ROW + 4*((COL + ROW) % 4)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shifted[4*gi];
        assign a1 = shifted[4*gi+1];
        assign a2 = shifted[4*gi+2];
        assign a3 = shifted[4*gi+3];
        assign mixed[4*gi]   = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
        assign mixed[4*gi+1] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
        assign mixed[4*gi+2] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
        assign mixed[4*gi+3] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
    end

    // SubWord(RotWord(w3)): byte gi of the rotated word comes from byte gi+1 of w3
    for (gi = 0; gi < 4; gi++) begin : g_key_sub
        localparam int SRC = (gi + 1) % 4;
        assign sub_rot[gi] = sbox(round_key[31-8*SRC -: 8]);
    end

    assign key_word[0] = round_key[127:96] ^ {sub_rot[0], sub_rot[1], sub_rot[2], sub_rot[3]}
                         ^ {rcon, 24'h000000};
    assign key_word[1] = round_key[95:64] ^ key_word[0];
    assign key_word[2] = round_key[63:32] ^ key_word[1];
    assign key_word[3] = round_key[31:0]  ^ key_word[2];
    assign next_round_key = {key_word[0], key_word[1], key_word[2], key_word[3]};

    for (gi = 0; gi < 16; gi++) begin : g_add_key
        assign next_state[127-8*gi -: 8] = (last_round ? shifted[gi] : mixed[gi])
                                           ^ next_round_key[127-8*gi -: 8];
    end

endmodule

// File: rtl/aes_encryptor.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly.
// start is sampled only in IDLE; done pulses for one cycle as cipher_text updates.
module aes_encryptor
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    aes_encryptor_if.slave bus
);

    aes_fsm_e     fsm_reg, fsm_next;
    logic [127:0] state_reg, round_key_reg, cipher_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   round_reg;
    logic         done_reg;
    logic         load, step, last_round;
    logic [127:0] next_state, next_round_key;

    assign last_round = (round_reg == NUM_ROUNDS);

    aes_round_comb u_round (
        .state          (state_reg),
        .round_key      (round_key_reg),
        .rcon           (rcon_reg),
        .last_round     (last_round),
        .next_state     (next_state),
        .next_round_key (next_round_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_reg <= IDLE;
        else        fsm_reg <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_reg;
        load     = 1'b0;
        step     = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (last_round) fsm_next = DONE;
            end
            DONE:    fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= '0;
            round_key_reg <= '0;
            cipher_reg    <= '0;
            rcon_reg      <= '0;
            round_reg     <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                state_reg     <= bus.plain_text ^ bus.key;
                round_key_reg <= bus.key;
                rcon_reg      <= RCON_INIT;
                round_reg     <= 4'd1;
            end else if (step) begin
                state_reg     <= next_state;
                round_key_reg <= next_round_key;
                rcon_reg      <= xtime(rcon_reg);
                round_reg     <= round_reg + 4'd1;
                if (last_round) begin
                    cipher_reg <= next_state;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign bus.done        = done_reg;
    assign bus.cipher_text = cipher_reg;

endmodule

// File: tb/tb_aes_encryptor.sv
// Self-checking bench for aes_encryptor: known FIPS-197 vectors, random vectors
// against an algebraic AES reference, busy/back-to-back handshake and reset abort.
module tb_aes_encryptor;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_encryptor_if bus ();

    aes_encryptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sbox_tab [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        s[r+4*c] = t[r+4*((c+r)%4)];
                if (rnd < 10) begin
                    for (int i = 0; i < 16; i++) t[i] = s[i];
                    for (int c = 0; c < 4; c++) begin
                        s[4*c]   = gf_mul(t[4*c], 8'h02) ^ gf_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 8'h02) ^ gf_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                        s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 8'h02) ^ gf_mul(t[4*c+3], 8'h03);
                        s[4*c+3] = gf_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 8'h02);
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge with the core idle; returns edges from start-sample to done.
    task automatic run_enc(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output int lat);
        bus.plain_text = pt;
        bus.key        = k;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        ct  = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                ct  = bus.cipher_text;
                break;
            end
        end
    endtask

    task automatic enc_and_check(input string tag, input logic [127:0] pt,
                                 input logic [127:0] k, input logic [127:0] exp);
        logic [127:0] ct;
        int lat;
        run_enc(pt, k, ct, lat);
        $display("txn %s pt=%h key=%h ct=%h lat=%0d", tag, pt, k, ct, lat);
        check({tag, "_latency"}, 128'(lat), 128'(10));
        check({tag, "_ct"}, ct, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_width"}, 128'(bus.done), 128'(0));
    endtask

    initial begin
        logic [127:0] pt, k, ct;
        int pulses, ndone, cyc;
        int times [3];
        logic [127:0] outs [3];

        build_sbox();
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.plain_text = '0;
        bus.key        = '0;
        repeat (3) @(negedge clk);
        check("reset_done", 128'(bus.done), 128'(0));
        check("reset_ct", bus.cipher_text, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        enc_and_check("fips_c1", C1_PT, C1_KEY, C1_CT);
        enc_and_check("fips_b", B_PT, B_KEY, B_CT);
        enc_and_check("all_zero", 128'h0, 128'h0, ZERO_CT);

        for (int v = 0; v < 16; v++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            enc_and_check("random", pt, k, ref_encrypt(pt, k));
        end

        // inputs changed and start re-pulsed while busy (including in DONE)
        bus.plain_text = C1_PT;
        bus.key        = C1_KEY;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.plain_text = {$urandom, $urandom, $urandom, $urandom};
        bus.key        = {$urandom, $urandom, $urandom, $urandom};
        pulses = 0;
        ct     = '0;
        for (int n = 1; n <= 30; n++) begin
            bus.start = (n == 3 || n == 11);
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                ct = bus.cipher_text;
            end
        end
        bus.start = 1'b0;
        $display("txn busy_start ct=%h done_pulses=%0d", ct, pulses);
        check("busy_pulses", 128'(pulses), 128'(1));
        check("busy_ct", ct, C1_CT);

        // start held high: back-to-back runs every 12 cycles
        bus.plain_text = C1_PT;
        bus.key        = C1_KEY;
        bus.start      = 1'b1;
        cyc   = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            times[i] = 0;
            outs[i]  = '0;
        end
        for (int n = 0; n < 45 && ndone < 3; n++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done) begin
                times[ndone] = cyc;
                outs[ndone]  = bus.cipher_text;
                ndone++;
            end
        end
        bus.start = 1'b0;
        $display("txn hold_start dones=%0d at %0d %0d %0d", ndone, times[0], times[1], times[2]);
        check("hold_count", 128'(ndone), 128'(3));
        check("hold_first", 128'(times[0]), 128'(11));
        check("hold_gap1", 128'(times[1] - times[0]), 128'(12));
        check("hold_gap2", 128'(times[2] - times[1]), 128'(12));
        for (int i = 0; i < 3; i++) check("hold_ct", outs[i], C1_CT);
        repeat (3) @(negedge clk);

        // reset asserted mid-operation, after round 5
        bus.plain_text = B_PT;
        bus.key        = B_KEY;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        $display("txn reset_abort done=%0b ct=%h", bus.done, bus.cipher_text);
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_ct", bus.cipher_text, 128'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_no_done", 128'(pulses), 128'(0));
        enc_and_check("after_reset", C1_PT, C1_KEY, C1_CT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_encryptor.md
Name: aes_encryptor

Overview:
- Iterative AES-128 encryption core (FIPS-197) that computes one round per clock.
- Round keys are expanded on the fly from the 128-bit cipher key, so no key RAM is needed.
- Sits as a standalone crypto block with a start/done handshake: a host loads plaintext and key, pulses start, and collects cipher_text when done pulses.

Parameters:
- None (fixed AES-128: 10 rounds, 128-bit block and key).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to begin encryption; sampled only in IDLE.
- plain_text  input  128  plaintext block; bits [127:120] are byte 0 (FIPS-197 column-major order).
- key  input  128  cipher key, same byte order.
- done  output  1  one-cycle pulse: cipher_text is valid.
- cipher_text  output  128  result register; holds its value until the next done.

Behaviour:
- Reset: state machine goes to IDLE; done=0, cipher_text=0, internal state/round-key/round counter=0.
- States: IDLE, ROUND, DONE.
- IDLE, with start=1 at a rising edge (edge E0):
  - state <= plain_text ^ key; round_key <= key; rcon <= 8'h01; round <= 1; go to ROUND.
  - plain_text and key are captured only at E0; later input changes are ignored.
- ROUND, one edge per round r = 1..10:
  - next_key: standard expansion, w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}, then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - rcon update: rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
  - Rounds 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next_key.
  - Round 10: state <= ShiftRows(SubBytes(state)) ^ next_key; MixColumns is skipped.
  - After the round-10 edge (E10), go to DONE.
- At E10, cipher_text <= final state and done <= 1. done is high for exactly one cycle (E10 to E11). Latency: done rises 10 edges after the start-sampling edge.
- DONE: one cycle, then back to IDLE unconditionally. If start is still high in IDLE, a new encryption begins at the next edge (minimum 12 cycles between start edges).
- start while busy (ROUND/DONE) is ignored; no queuing.
- ShiftRows: row r is rotated left by r bytes (row 0 unchanged).
- MixColumns: per column, matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
- SubBytes: standard AES S-box (combinational lookup). 20 instances: 16 for the state, 4 for key expansion.
- Reset asserted mid-operation: immediate abort; done=0, cipher_text=0; no spurious done afterwards.
- All data-path logic is combinational between the state/round_key registers; no multicycle paths.

Decomposition:
- Package aes_pkg:
  - sbox function (256-entry case);
  - xtime and gmul2/gmul3 functions;
  - state enum (IDLE/ROUND/DONE);
  - constants NUM_ROUNDS=10, RCON_INIT=8'h01.
- Sub-module aes_round_comb (combinational):
  - inputs: state, round_key, last_round flag;
  - outputs: next_state and next_round_key (SubBytes, ShiftRows, optional MixColumns, key expansion, AddRoundKey).
- Top level holds the FSM, registers, counter and rcon.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, start pulse -> done exactly 10 edges later, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> cipher_text 3925841d02dc09fbdc118597196a0b32; done high for 1 cycle only.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Input-change and busy-start check:
  - Change plain_text/key and pulse start during rounds -> result unchanged from the first vector; only one done pulse.
  - Hold start high continuously -> back-to-back encryptions, done every 12 cycles, identical results.
- Assert rst_n low at round 5 -> done=0, cipher_text=0 immediately; release reset, run C.1 again -> correct result.
